// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: rebuilds VGA pixel coordinates and the active window from hsync/vsync edges,
// measures line/frame length and reports lock. Define VGA_MON_CHECKSUM_EN to build the frame_sum checksum.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_DISPLAY   = 640,
    parameter int V_DISPLAY   = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        video_on,
    output logic        locked,
    output logic [11:0] h_meas,
    output logic [11:0] v_meas,
    output logic        err,
    output logic [15:0] frame_sum
);

    localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
    localparam logic [11:0] V_TOTAL_C = 12'(V_TOTAL);
    localparam logic [11:0] H_LO      = 12'(H_START);
    localparam logic [11:0] H_HI      = 12'(H_START + H_DISPLAY);
    localparam logic [11:0] V_LO      = 12'(V_START);
    localparam logic [11:0] V_HI      = 12'(V_START + V_DISPLAY);
    localparam logic [11:0] H_TMO     = 12'(2 * H_TOTAL);
    localparam logic [11:0] V_TMO     = 12'(2 * V_TOTAL);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state;
    logic        hsync_s1, hsync_s2, vsync_s1, vsync_s2;
    logic        h_edge, v_edge;
    logic [11:0] h_cnt, v_cnt;
    logic [3:0]  good;
    logic        line_bad;
    logic        h_ok, v_ok, timeout, frame_ok;

    // Stage s1/s2: sync sampling, then registered falling-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_s1 <= 1'b1;
            hsync_s2 <= 1'b1;
            vsync_s1 <= 1'b1;
            vsync_s2 <= 1'b1;
            h_edge   <= 1'b0;
            v_edge   <= 1'b0;
        end else begin
            hsync_s1 <= hsync;
            hsync_s2 <= hsync_s1;
            vsync_s1 <= vsync;
            vsync_s2 <= vsync_s1;
            h_edge   <= !hsync_s1 && hsync_s2;
            v_edge   <= !vsync_s1 && vsync_s2;
        end
    end

    // Counter stage: saturating counters and length measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            h_meas <= '0;
            v_meas <= '0;
        end else begin
            if (h_edge) begin
                h_cnt  <= '0;
                h_meas <= h_cnt + 12'd1;
            end else if (h_cnt != 12'hfff) begin
                h_cnt <= h_cnt + 12'd1;
            end
            if (v_edge) begin
                v_cnt  <= '0;
                v_meas <= v_cnt + 12'd1;
            end else if (h_edge && v_cnt != 12'hfff) begin
                v_cnt <= v_cnt + 12'd1;
            end
        end
    end

    assign h_ok     = (h_cnt + 12'd1) == H_TOTAL_C;
    assign v_ok     = (v_cnt + 12'd1) == V_TOTAL_C;
    assign timeout  = (h_cnt == H_TMO) || (v_cnt == V_TMO);
    // The hsync edge coinciding with vsync closes the frame's last line, so it counts too
    assign frame_ok = !line_bad && (!h_edge || h_ok) && v_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good     <= '0;
            line_bad <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state != SEARCH && timeout) begin
                state  <= SEARCH;
                locked <= 1'b0;
                good   <= '0;
                err    <= 1'b1;
            end else begin
                case (state)
                    SEARCH: begin
                        if (v_edge) begin
                            state    <= TRACK;
                            good     <= '0;
                            line_bad <= 1'b0;
                        end
                    end
                    TRACK: begin
                        if (v_edge) begin
                            line_bad <= 1'b0;
                            if (frame_ok) begin
                                good <= good + 4'd1;
                                if (good + 4'd1 == LOCK_N) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                good <= '0;
                                err  <= 1'b1;
                            end
                        end else if (h_edge && !h_ok) begin
                            line_bad <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if ((h_edge && !h_ok) || (v_edge && !v_ok)) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    // Output stage: window and coordinates, one cycle behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            video_on <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
        end else if (locked && h_cnt >= H_LO && h_cnt < H_HI && v_cnt >= V_LO && v_cnt < V_HI) begin
            video_on <= 1'b1;
            pixel_x  <= h_cnt - H_LO;
            pixel_y  <= v_cnt - V_LO;
        end else begin
            video_on <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [2:0]  rgb_s1, rgb_s2, rgb_s3, rgb_p4;
    logic [15:0] acc;

    // rgb is delayed to match h_cnt (s3) and then video_on (p4)
    always_ff @(posedge clk) begin
        rgb_s1 <= rgb;
        rgb_s2 <= rgb_s1;
        rgb_s3 <= rgb_s2;
        rgb_p4 <= rgb_s3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (!locked) begin
            acc <= '0;
        end else if (v_edge) begin
            frame_sum <= acc;
            acc       <= '0;
        end else if (video_on) begin
            acc <= acc + {13'b0, rgb_p4};
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb;
    assign frame_sum  = 16'd0;
`endif

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side counterpart of the VGA timing core. It samples a VGA stream (hsync, vsync, 3-bit rgb) in the 25 MHz pixel clock domain and rebuilds pixel coordinates and the video_on window from the sync edges alone. It measures line and frame lengths, and raises a lock flag once timing matches 640x480@60 for a configurable number of frames. It sits on the loopback/capture path for self-check of the generator and banner logic, and feeds test overlays.

## Interface
- H_TOTAL, 800: expected clocks per line.
- V_TOTAL, 525: expected lines per frame.
- H_START, 144: h_cnt value of first active pixel (retrace + back porch).
- V_START, 35: v_cnt value of first active line.
- H_DISPLAY, 640: active pixels per line.
- V_DISPLAY, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive good frames required for lock (1..15).
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  synchronous, active-high reset.
- hsync  in  1  horizontal sync, active-low.
- vsync  in  1  vertical sync, active-low.
- rgb  in  3  pixel colour.
- pixel_x  out  12  recovered column, 0..639 inside window, 0 outside.
- pixel_y  out  12  recovered row, 0..479 inside window, 0 outside.
- video_on  out  1  recovered active-video window.
- locked  out  1  timing matches parameters.
- h_meas  out  12  last measured line length in clocks.
- v_meas  out  12  last measured frame length in lines.
- err  out  1  one-cycle pulse on a timing mismatch or timeout.
- frame_sum  out  16  checksum of last frame (see Configuration).

## Operation
- hsync, vsync, rgb are registered once (stage s1), then hsync/vsync once more (s2). An assertion edge is s1==0 && s2==1.
- h_cnt (12b): cleared on an hsync edge, otherwise increments and saturates at 4095.
- v_cnt (12b): cleared on a vsync edge, otherwise increments on each hsync edge and saturates at 4095. On a cycle with both edges, the vsync clear wins.
- On an hsync edge, h_meas <= h_cnt+1. On a vsync edge, v_meas <= v_cnt+1.
- video_on = locked && H_START<=h_cnt<H_START+H_DISPLAY && V_START<=v_cnt<V_START+V_DISPLAY.
- pixel_x = h_cnt-H_START and pixel_y = v_cnt-V_START when video_on; both 0 otherwise.
- FSM:
  - SEARCH: wait for the first vsync edge, then go to TRACK with good=0.
  - TRACK: at each vsync edge, if every line in the frame had h_cnt+1==H_TOTAL and v_cnt+1==V_TOTAL, then good++; otherwise good=0 and err fires. Go to LOCKED when good reaches LOCK_FRAMES.
  - LOCKED: any mismatching hsync or vsync edge fires err and returns to SEARCH.
- Timeout, in any state except SEARCH: h_cnt reaching 2*H_TOTAL, or v_cnt reaching 2*V_TOTAL, fires err, returns to SEARCH and clears locked.
- The first partial line and frame after reset or SEARCH entry are not checked.

## Timing
- Reset values:
  - pixel_x, pixel_y, h_meas, v_meas, frame_sum: 0.
  - video_on, locked, err: 0.
  - h_cnt, v_cnt: 0. FSM: SEARCH.
- Pin-to-count latency: hsync sampled low at edge N, previously high, gives h_cnt==0 after edge N+2.
- All outputs are registered. pixel_x, pixel_y and video_on lag the registered h_cnt and v_cnt by one cycle and align with the registered rgb.
- locked rises the cycle after the qualifying vsync edge and falls the cycle after the failing edge.
- err is exactly 1 cycle wide.
- rst asserted mid-frame restores all reset values on the next edge. Re-lock needs one unchecked frame plus LOCK_FRAMES good frames.

## Configuration
- VGA_MON_CHECKSUM_EN defined:
  - A 16-bit accumulator adds {13'b0,rgb} on every video_on cycle.
  - On each vsync edge while locked, frame_sum <= accumulator and the accumulator clears. The accumulator wraps modulo 2^16.
- VGA_MON_CHECKSUM_EN undefined: no accumulator is built and frame_sum is constant 0.

## Test plan
- Nominal 800x525 stream from the timing core, LOCK_FRAMES=2 -> locked rises after the third vsync edge; h_meas=800 and v_meas=525; err never pulses.
- Locked stream with one line shortened to 799 clocks -> err for 1 cycle at that hsync edge, locked=0, FSM=SEARCH; re-locks 3 frames later.
- hsync held high 1600 clocks after lock -> err plus unlock at h_cnt==1600; pixel_x=0 and video_on=0 thereafter.
- Locked, probe the first active pixel -> video_on=1 with pixel_x=0, pixel_y=0 at h_cnt=144, v_cnt=35; last pixel is 639/479 at h_cnt=783, v_cnt=514.
- rst asserted for 1 cycle mid-frame while locked -> next cycle all outputs 0; locked returns after 3 vsync edges.
- VGA_MON_CHECKSUM_EN defined, solid rgb=3'b111 frame -> frame_sum = (307200*7) mod 65536 = 53248; undefined -> frame_sum stays 0.
